// File: rtl/sdram_burst_scheduler_pkg.sv
// Shared encodings for the SDRAM burst scheduler.
//   cmd_e   : command code presented on REQ_CMD (idle / read / write)
//   state_e : scheduler FSM states
package sdram_sched_pkg;

  typedef enum logic [1:0] {
    CMD_IDLE  = 2'b00,
    CMD_READ  = 2'b01,
    CMD_WRITE = 2'b10
  } cmd_e;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_DONE
  } state_e;

endpackage

// File: rtl/sdram_burst_scheduler_if.sv
// Burst request bus between the scheduler and the SDRAM command layer.
//   REQ_CMD/REQ_ADDR/REQ_LEN : burst command, start address, length
//   REQ_ACK                  : command accepted by the command layer
//   REQ_DONE                 : one-cycle pulse at the end of the burst
//   GNT_WR/GNT_RD            : one-hot channel grants gating the FIFO strobes
interface sdram_burst_scheduler_if #(
  parameter int NCH   = 2,
  parameter int ASIZE = 23,
  parameter int LSIZE = 9
);
  logic [1:0]       REQ_CMD;
  logic [ASIZE-1:0] REQ_ADDR;
  logic [LSIZE-1:0] REQ_LEN;
  logic             REQ_ACK;
  logic             REQ_DONE;
  logic [NCH-1:0]   GNT_WR;
  logic [NCH-1:0]   GNT_RD;

  modport master (output REQ_CMD, REQ_ADDR, REQ_LEN, GNT_WR, GNT_RD,
                  input  REQ_ACK, REQ_DONE);
  modport slave  (input  REQ_CMD, REQ_ADDR, REQ_LEN, GNT_WR, GNT_RD,
                  output REQ_ACK, REQ_DONE);
endinterface

// File: rtl/sdram_rr_arbiter.sv
// Combinational round-robin arbiter over 2*NCH requestors.
//   req : request vector, writes at [NCH-1:0], reads at [2NCH-1:NCH]
//   ptr : index where the search starts
//   gnt : one-hot winner
//   vld : some request won
// With WR_PRIO != 0 the reads are masked whenever any write requests, so
// the rotation effectively runs over writes only in that case.
module sdram_rr_arbiter #(
  parameter  int NCH     = 2,
  parameter  int WR_PRIO = 1,
  localparam int N       = 2 * NCH,
  localparam int PW      = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic          vld
);

  logic [N-1:0] req_m;
  logic [PW:0]  pos;

  always_comb begin
    req_m = req;
    if (WR_PRIO != 0 && |req[NCH-1:0]) req_m[N-1:NCH] = '0;
    gnt = '0;
    vld = 1'b0;
    pos = '0;
    for (int k = 0; k < N; k++) begin
      pos = {1'b0, ptr} + (PW+1)'(k);
      if (pos >= (PW+1)'(N)) pos = pos - (PW+1)'(N);
      if (!vld && req_m[pos[PW-1:0]]) begin
        gnt[pos[PW-1:0]] = 1'b1;
        vld              = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sdram_burst_scheduler.sv
// Multi-channel SDRAM burst scheduler. Keeps a wrapping address pointer per
// write and read channel, arbitrates eligible channels and issues one burst at
// a time over a CMD/ACK/DONE handshake.
//   CLK, RESET_N           : clock, async active-low reset
//   CH_EN                  : per-channel enable (both directions)
//   WR_/RD_START, _MAX     : pointer reload value and wrap limit per channel
//   WR_/RD_LEN             : burst length per channel
//   WR_/RD_LOAD            : reload the pointer from START
//   WR_LEVEL / RD_LEVEL    : write FIFO readable words / read FIFO held words
//   req                    : burst request bus (master side)
//   BUSY                   : FSM outside IDLE
module sdram_burst_scheduler
  import sdram_sched_pkg::*;
#(
  parameter int NCH      = 2,
  parameter int ASIZE    = 23,
  parameter int LSIZE    = 9,
  parameter int USEDW    = 16,
  parameter int RD_DEPTH = 512,
  parameter int WR_PRIO  = 1
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
  input  logic [NCH-1:0]       CH_EN,
  input  logic [NCH*ASIZE-1:0] WR_START,
  input  logic [NCH*ASIZE-1:0] WR_MAX,
  input  logic [NCH*LSIZE-1:0] WR_LEN,
  input  logic [NCH-1:0]       WR_LOAD,
  input  logic [NCH*USEDW-1:0] WR_LEVEL,
  input  logic [NCH*ASIZE-1:0] RD_START,
  input  logic [NCH*ASIZE-1:0] RD_MAX,
  input  logic [NCH*LSIZE-1:0] RD_LEN,
  input  logic [NCH-1:0]       RD_LOAD,
  input  logic [NCH*USEDW-1:0] RD_LEVEL,
  sdram_burst_scheduler_if.master req,
  output logic                 BUSY
);

  localparam int N  = 2 * NCH;
  localparam int PW = $clog2(N);

  state_e                      state;
  cmd_e                        req_cmd;
  logic [ASIZE-1:0]            req_addr;
  logic [LSIZE-1:0]            req_len;
  logic [NCH-1:0]              gnt_wr, gnt_rd;
  logic                        busy;
  logic [PW-1:0]               rr_ptr;
  logic [NCH-1:0][ASIZE-1:0]   wr_ptr, rd_ptr, wr_nxt, rd_nxt;

  logic [N-1:0]                elig, win;
  logic                        win_vld;
  logic [PW-1:0]               win_idx, rr_nxt;
  logic [ASIZE-1:0]            sel_addr;
  logic [LSIZE-1:0]            sel_len;
  logic                        done_fire;

  // Advance by one burst; wrap to start once the end would reach max.
  function automatic logic [ASIZE-1:0] next_ptr(input logic [ASIZE-1:0] p,
                                                input logic [LSIZE-1:0] l,
                                                input logic [ASIZE-1:0] s,
                                                input logic [ASIZE-1:0] m);
    logic [ASIZE:0] sum;
    sum = {1'b0, p} + (ASIZE+1)'(l);
    return (sum < {1'b0, m}) ? sum[ASIZE-1:0] : s;
  endfunction

  always_comb begin
    elig = '0;
    for (int i = 0; i < NCH; i++) begin
      elig[i] = CH_EN[i] && !WR_LOAD[i] && (WR_LEN[i*LSIZE +: LSIZE] != '0) &&
                (WR_LEVEL[i*USEDW +: USEDW] >= USEDW'(WR_LEN[i*LSIZE +: LSIZE]));
      // Read needs room for the whole burst; one extra bit keeps the sum exact.
      elig[NCH+i] = CH_EN[i] && !RD_LOAD[i] && (RD_LEN[i*LSIZE +: LSIZE] != '0) &&
                    (({1'b0, RD_LEVEL[i*USEDW +: USEDW]} +
                      (USEDW+1)'(RD_LEN[i*LSIZE +: LSIZE])) <= (USEDW+1)'(RD_DEPTH));
      wr_nxt[i] = next_ptr(wr_ptr[i], WR_LEN[i*LSIZE +: LSIZE],
                           WR_START[i*ASIZE +: ASIZE], WR_MAX[i*ASIZE +: ASIZE]);
      rd_nxt[i] = next_ptr(rd_ptr[i], RD_LEN[i*LSIZE +: LSIZE],
                           RD_START[i*ASIZE +: ASIZE], RD_MAX[i*ASIZE +: ASIZE]);
    end
  end

  sdram_rr_arbiter #(.NCH(NCH), .WR_PRIO(WR_PRIO)) u_arb (
    .req (elig),
    .ptr (rr_ptr),
    .gnt (win),
    .vld (win_vld)
  );

  always_comb begin
    sel_addr = '0;
    sel_len  = '0;
    win_idx  = '0;
    for (int j = 0; j < NCH; j++) begin
      if (win[j]) begin
        sel_addr = wr_ptr[j];
        sel_len  = WR_LEN[j*LSIZE +: LSIZE];
        win_idx  = PW'(j);
      end
      if (win[NCH+j]) begin
        sel_addr = rd_ptr[j];
        sel_len  = RD_LEN[j*LSIZE +: LSIZE];
        win_idx  = PW'(NCH + j);
      end
    end
    rr_nxt = (win_idx == PW'(N - 1)) ? '0 : win_idx + PW'(1);
  end

  assign done_fire = (state == WAIT_DONE) && req.REQ_DONE;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state    <= IDLE;
      req_cmd  <= CMD_IDLE;
      req_addr <= '0;
      req_len  <= '0;
      gnt_wr   <= '0;
      gnt_rd   <= '0;
      busy     <= 1'b0;
      rr_ptr   <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      case (state)
        IDLE: if (win_vld) begin
          // Command goes out with the grant, i.e. from the first ISSUE cycle.
          gnt_wr   <= win[NCH-1:0];
          gnt_rd   <= win[N-1:NCH];
          req_addr <= sel_addr;
          req_len  <= sel_len;
          req_cmd  <= (|win[NCH-1:0]) ? CMD_WRITE : CMD_READ;
          rr_ptr   <= rr_nxt;
          busy     <= 1'b1;
          state    <= ISSUE;
        end
        ISSUE: if (req.REQ_ACK) begin
          req_cmd <= CMD_IDLE;
          state   <= WAIT_DONE;
        end
        WAIT_DONE: if (req.REQ_DONE) begin
          gnt_wr <= '0;
          gnt_rd <= '0;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
      // LOAD outranks the DONE advance for the same pointer.
      for (int i = 0; i < NCH; i++) begin
        if (WR_LOAD[i])                  wr_ptr[i] <= WR_START[i*ASIZE +: ASIZE];
        else if (done_fire && gnt_wr[i]) wr_ptr[i] <= wr_nxt[i];
        if (RD_LOAD[i])                  rd_ptr[i] <= RD_START[i*ASIZE +: ASIZE];
        else if (done_fire && gnt_rd[i]) rd_ptr[i] <= rd_nxt[i];
      end
    end
  end

  assign req.REQ_CMD  = req_cmd;
  assign req.REQ_ADDR = req_addr;
  assign req.REQ_LEN  = req_len;
  assign req.GNT_WR   = gnt_wr;
  assign req.GNT_RD   = gnt_rd;
  assign BUSY         = busy;

endmodule
